// File: rtl/out_buffer_pkg.sv
// Shared constants and helpers for the out_buffer_reg output staging FIFO.
// Optional OutParity support is enabled with the OUT_PARITY_EN macro.
package out_buffer_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int DEPTH_DEF = 4;
  localparam int PTR_W     = $clog2(DEPTH_DEF);
  localparam int CNT_W     = PTR_W + 1;

  // Out powers up and resets to all zeros, replicated to any width.
  localparam logic OUT_RST_BIT = 1'b0;

  // Parity over a zero-extended word; words wider than 64 bits are not supported.
  function automatic logic parity_even(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/out_buffer_mem.sv
// DEPTH-entry storage for the output FIFO: synchronous write, combinational read.
// Contents are not reset; occupancy tracking in the parent decides what is valid.
module out_buffer_mem #(
  parameter int DW    = 4,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_reg[waddr] <= wdata;
  end

  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/out_buffer_reg.sv
// Show-ahead output FIFO between the internal bus and the output pins, valid/ack handshake.
// Define OUT_PARITY_EN to add the registered OutParity output (parity stored per entry).
module out_buffer_reg
  import out_buffer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   MainClock,
  input  logic                   MainReset,
  input  logic [WIDTH-1:0]       IB,
  input  logic                   LoadOut,
  input  logic                   OutAck,
  output logic [WIDTH-1:0]       Out,
  output logic                   OutValid,
  output logic                   Full,
  output logic                   Empty,
  output logic [$clog2(DEPTH):0] Count,
  output logic                   Overflow
`ifdef OUT_PARITY_EN
  ,
  output logic                   OutParity
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
`ifdef OUT_PARITY_EN
  localparam int SW = WIDTH + 1;
`else
  localparam int SW = WIDTH;
`endif

  logic [PW-1:0]    rptr_reg, rptr_next, wptr_reg, wptr_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             overflow_reg, overflow_next;
  logic             valid_reg, valid_next;
  logic [WIDTH-1:0] out_reg, out_next;
  logic             full, empty, push, pop;
  logic [SW-1:0]    wdata, rdata, head_data;
  logic             head_load;
`ifdef OUT_PARITY_EN
  logic             parity_reg, parity_next;
`endif

`ifdef OUT_PARITY_EN
  assign wdata = {parity_even(64'(IB)), IB};
`else
  assign wdata = IB;
`endif

  // The memory is read one past the head: that is the word Out shows after a pop.
  out_buffer_mem #(.DW(SW), .DEPTH(DEPTH), .AW(PW)) u_mem (
    .clk   (MainClock),
    .we    (push),
    .waddr (wptr_reg),
    .wdata (wdata),
    .raddr (rptr_reg + 1'b1),
    .rdata (rdata)
  );

  always_comb begin
    full          = (count_reg == CW'(DEPTH));
    empty         = (count_reg == '0);
    push          = LoadOut && (!full || OutAck);
    pop           = OutAck && valid_reg;
    wptr_next     = push ? wptr_reg + 1'b1 : wptr_reg;
    rptr_next     = pop  ? rptr_reg + 1'b1 : rptr_reg;
    overflow_next = overflow_reg || (LoadOut && full && !OutAck);
    count_next    = count_reg;
    if (push && !pop)      count_next = count_reg + 1'b1;
    else if (pop && !push) count_next = count_reg - 1'b1;
    valid_next    = (count_next != '0);

    // The incoming word bypasses storage when it becomes the head immediately.
    head_load = 1'b0;
    head_data = rdata;
    if (push && (empty || (pop && count_reg == CW'(1)))) begin
      head_load = 1'b1;
      head_data = wdata;
    end else if (pop && count_reg > CW'(1)) begin
      head_load = 1'b1;
    end
    out_next = head_load ? head_data[WIDTH-1:0] : out_reg;
`ifdef OUT_PARITY_EN
    parity_next = head_load ? head_data[WIDTH] : parity_reg;
`endif
  end

  always_ff @(posedge MainClock or negedge MainReset) begin
    if (!MainReset) begin
      rptr_reg     <= '0;
      wptr_reg     <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      valid_reg    <= 1'b0;
      out_reg      <= {WIDTH{OUT_RST_BIT}};
`ifdef OUT_PARITY_EN
      parity_reg   <= 1'b0;
`endif
    end else begin
      rptr_reg     <= rptr_next;
      wptr_reg     <= wptr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
      valid_reg    <= valid_next;
      out_reg      <= out_next;
`ifdef OUT_PARITY_EN
      parity_reg   <= parity_next;
`endif
    end
  end

  assign Out      = out_reg;
  assign OutValid = valid_reg;
  assign Full     = full;
  assign Empty    = empty;
  assign Count    = count_reg;
  assign Overflow = overflow_reg;
`ifdef OUT_PARITY_EN
  assign OutParity = parity_reg;
`endif

endmodule

// File: tb/tb_out_buffer_reg.sv
// Scoreboard bench for out_buffer_reg: stimulus queues expected words, a monitor checks pops.
module tb_out_buffer_reg;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic             MainClock = 1'b0;
  logic             MainReset = 1'b0;
  logic [WIDTH-1:0] IB = '0;
  logic             LoadOut = 1'b0;
  logic             OutAck = 1'b0;
  logic [WIDTH-1:0] Out;
  logic             OutValid, Full, Empty, Overflow;
  logic [2:0]       Count;
`ifdef OUT_PARITY_EN
  logic             OutParity;
`endif

  int checks = 0;
  int failures = 0;
  logic [WIDTH-1:0] exp_q[$];
  int mcount = 0;

  out_buffer_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .MainClock (MainClock),
    .MainReset (MainReset),
    .IB        (IB),
    .LoadOut   (LoadOut),
    .OutAck    (OutAck),
    .Out       (Out),
    .OutValid  (OutValid),
    .Full      (Full),
    .Empty     (Empty),
    .Count     (Count),
    .Overflow  (Overflow)
`ifdef OUT_PARITY_EN
    ,
    .OutParity (OutParity)
`endif
  );

  always #5 MainClock = ~MainClock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // One clock of stimulus; the expected queue only sees words the buffer must accept.
  task automatic cycle(input logic l, input logic [WIDTH-1:0] d, input logic a);
    LoadOut = l;
    IB      = d;
    OutAck  = a;
    if (l && (mcount < DEPTH || a)) exp_q.push_back(d);
    if (l && (mcount < DEPTH || a) && !(a && mcount > 0)) mcount++;
    else if (!(l && (mcount < DEPTH || a)) && a && mcount > 0) mcount--;
    @(posedge MainClock);
    #1;
    LoadOut = 1'b0;
    OutAck  = 1'b0;
  endtask

  // Monitor: a pop happens on the next edge whenever Out is valid and acknowledged.
  initial begin
    forever begin
      @(negedge MainClock);
      if (MainReset && OutValid && OutAck) begin
        if (exp_q.size() == 0) begin
          chk("pop_unexpected", 32'(Out), 32'hDEAD);
        end else begin
          chk("pop_data", 32'(Out), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #22;
    chk("rst_out", 32'(Out), 32'h0);
    chk("rst_valid", 32'(OutValid), 32'h0);
    chk("rst_count", 32'(Count), 32'h0);
    chk("rst_empty", 32'(Empty), 32'h1);
    chk("rst_full", 32'(Full), 32'h0);
    chk("rst_overflow", 32'(Overflow), 32'h0);
    MainReset = 1'b1;
    @(posedge MainClock);
    #1;

    // Single-word latency and drain hold
    cycle(1'b1, 4'hA, 1'b0);
    chk("lat_out", 32'(Out), 32'hA);
    chk("lat_valid", 32'(OutValid), 32'h1);
    chk("lat_count", 32'(Count), 32'h1);
    chk("lat_empty", 32'(Empty), 32'h0);
    cycle(1'b0, 4'h0, 1'b1);
    chk("drain_valid", 32'(OutValid), 32'h0);
    chk("drain_out_hold", 32'(Out), 32'hA);
    chk("drain_empty", 32'(Empty), 32'h1);

    // Fill to full
    for (int i = 1; i <= 4; i++) cycle(1'b1, 4'(i), 1'b0);
    chk("fill_full", 32'(Full), 32'h1);
    chk("fill_count", 32'(Count), 32'h4);
    chk("fill_head", 32'(Out), 32'h1);

    // Push and pop together while full
    cycle(1'b1, 4'h9, 1'b1);
    chk("simfull_count", 32'(Count), 32'h4);
    chk("simfull_overflow", 32'(Overflow), 32'h0);
    chk("simfull_head", 32'(Out), 32'h2);

    // Dropped push while full
    cycle(1'b1, 4'hF, 1'b0);
    chk("ovf_count", 32'(Count), 32'h4);
    chk("ovf_flag", 32'(Overflow), 32'h1);
    chk("ovf_head", 32'(Out), 32'h2);
    for (int i = 0; i < 4; i++) cycle(1'b0, 4'h0, 1'b1);
    chk("ovf_drain_valid", 32'(OutValid), 32'h0);
    chk("ovf_drain_out", 32'(Out), 32'h9);
    chk("ovf_sticky", 32'(Overflow), 32'h1);
    chk("ovf_drain_empty", 32'(Empty), 32'h1);

    // Ack with nothing valid changes nothing
    cycle(1'b0, 4'h0, 1'b1);
    chk("idle_ack_count", 32'(Count), 32'h0);
    chk("idle_ack_out", 32'(Out), 32'h9);

    // Push and pop together at Count==1
    cycle(1'b1, 4'h5, 1'b0);
    cycle(1'b1, 4'h6, 1'b1);
    chk("one_count", 32'(Count), 32'h1);
    chk("one_head", 32'(Out), 32'h6);
    cycle(1'b0, 4'h0, 1'b1);

    // Streaming across pointer wrap
    cycle(1'b1, 4'h0, 1'b0);
    cycle(1'b1, 4'h1, 1'b0);
    for (int i = 2; i < 10; i++) cycle(1'b1, 4'(i), 1'b1);
    chk("wrap_count", 32'(Count), 32'h2);
    chk("wrap_head", 32'(Out), 32'h8);
    cycle(1'b0, 4'h0, 1'b1);
    cycle(1'b0, 4'h0, 1'b1);
    chk("wrap_empty", 32'(Empty), 32'h1);

`ifdef OUT_PARITY_EN
    cycle(1'b1, 4'h7, 1'b0);
    chk("parity_7", 32'(OutParity), 32'h1);
    cycle(1'b1, 4'h3, 1'b1);
    chk("parity_3", 32'(OutParity), 32'h0);
    cycle(1'b0, 4'h0, 1'b1);
    chk("parity_hold", 32'(OutParity), 32'h0);
`endif

    // Asynchronous reset mid-stream with three words held
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'(i + 4'hB), 1'b0);
    chk("pre_rst_count", 32'(Count), 32'h3);
    #2;
    MainReset = 1'b0;
    #1;
    chk("arst_out", 32'(Out), 32'h0);
    chk("arst_valid", 32'(OutValid), 32'h0);
    chk("arst_count", 32'(Count), 32'h0);
    chk("arst_empty", 32'(Empty), 32'h1);
    chk("arst_overflow", 32'(Overflow), 32'h0);
    exp_q.delete();
    mcount = 0;
    #2;
    MainReset = 1'b1;
    @(posedge MainClock);
    #1;
    cycle(1'b1, 4'hC, 1'b0);
    chk("post_rst_out", 32'(Out), 32'hC);
    cycle(1'b0, 4'h0, 1'b1);

    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
